// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout master: burst-reads one frame over Avalon-MM into a show-ahead
// FIFO and replays it downstream as a valid/ready stream framed by sop/eop.
//
// state | meaning
// IDLE  | waiting for frame_start; late read beats are dropped
// ISSUE | issuing bursts whenever FIFO space covers the next burst
// DRAIN | all words requested; waiting for the eop word to leave
module fb_scanout_reader #(
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 256,
    parameter int FRAME_WORDS = 76800
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [28:0] frame_base,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic [28:0] avm_address,
    output logic [7:0]  avm_burstcount,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [63:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [63:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop
);
    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [RW-1:0] FRAME_LEN = RW'(FRAME_WORDS);
    localparam logic [RW-1:0] LAST_IDX  = RW'(FRAME_WORDS - 1);
    localparam logic [OW:0]   DEPTH_X   = (OW + 1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_N   = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [28:0]   addr;
    logic [RW-1:0] req_left;
    logic [RW-1:0] out_idx;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [63:0]   mem [FIFO_DEPTH];

    logic [7:0]    burst;
    logic          credit_ok;
    logic          start_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          eop_xfer;
    logic [OW-1:0] out_add;
    logic [OW-1:0] out_sub;

    always_comb begin
        burst     = (32'(req_left) < BURST_LEN) ? 8'(req_left) : 8'(BURST_LEN);
        // Space already promised to in-flight beats counts as used.
        credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding} + (OW + 1)'(burst)) <= DEPTH_X;
        start_ok  = (state == IDLE) && frame_start && !frame_done;
        accept    = avm_read && !avm_waitrequest;
        push      = avm_readdatavalid && (outstanding != '0);
        pop       = st_valid && st_ready;
        eop_xfer  = pop && st_eop;
        out_add   = accept ? OW'(burst) : '0;
        out_sub   = OW'(push);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = ISSUE;
            ISSUE:   if (accept && (RW'(burst) == req_left)) state_nxt = DRAIN;
            DRAIN:   if ((outstanding == '0) && eop_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        avm_read       = (state == ISSUE) && credit_ok;
        avm_address    = avm_read ? addr : '0;
        avm_burstcount = avm_read ? burst : '0;
        st_valid       = (fifo_count != '0);
        st_data        = st_valid ? mem[rd_ptr] : '0;
        st_sop         = st_valid && (out_idx == '0);
        st_eop         = st_valid && (out_idx == LAST_IDX);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            addr        <= '0;
            req_left    <= '0;
            out_idx     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && (outstanding == '0) && eop_xfer;
            if (start_ok) begin
                addr     <= frame_base;
                req_left <= FRAME_LEN;
                out_idx  <= '0;
            end else begin
                if (accept) begin
                    addr     <= addr + 29'(burst);
                    req_left <= req_left - RW'(burst);
                end
                if (pop) begin
                    out_idx <= out_idx + RW'(1);
                end
            end
            outstanding <= outstanding + out_add - out_sub;
            fifo_count  <= fifo_count + OW'(push) - OW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= avm_readdata;
        end
    end

`ifndef SYNTHESIS
    // Credit accounting guarantees a free slot for every returning beat.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset) begin
            assert (!(push && (fifo_count == DEPTH_N)));
        end
    end
`endif

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: Avalon slave model, stream sink and a word-count
// reference model checked every cycle, plus directed literal checks.
module tb_fb_scanout_reader;
    localparam int BL = 16;
    localparam int FD = 32;
    localparam int FW = 40;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [28:0] frame_base;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic [28:0] avm_address;
    logic [7:0]  avm_burstcount;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [63:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [63:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;

    always #5 clk_clk = ~clk_clk;

    fb_scanout_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .FRAME_WORDS(FW)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .frame_base(frame_base),
        .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop)
    );

    int checks = 0;
    int failures = 0;

    // model: frame progress as plain word counts
    bit          chk_en;
    bit          m_active;
    bit          m_done;
    int          m_req, m_ret, m_pop, m_acc;
    logic [28:0] m_base;
    // observations of the DUT
    int          done_cnt, dut_xfers, sop_at, eop_at, stall_cnt, stall_seen;
    logic [28:0] slave_q[$];
    logic [28:0] bl_addr[$];
    int          bl_cnt[$];
    int          wr_mode, rdv_mode, rdy_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [28:0] a);
        return {3'b000, a, 3'b101, ~a};
    endfunction

    function automatic int exp_burst(input int req);
        return (FW - req < BL) ? FW - req : BL;
    endfunction

    // compare + model update, on the falling edge
    initial begin : compare
        logic [28:0] a_exp;
        bit          exp_rd, eop_now, start_ok;
        int          avail;
        forever begin
            @(negedge clk_clk);
            avail = m_ret - m_pop;
            if (chk_en) begin
                check("busy", busy, m_active);
                check("frame_done", frame_done, m_done);
                check("st_valid", st_valid, avail > 0);
                if (avail > 0) begin
                    a_exp = m_base + 29'(m_pop);
                    check("st_data", st_data, word_of(a_exp));
                    check("st_sop", st_sop, m_pop == 0);
                    check("st_eop", st_eop, m_pop == FW - 1);
                end
                exp_rd = m_active && (m_req < FW) && ((FD - (m_req - m_pop)) >= exp_burst(m_req));
                check("avm_read", avm_read, exp_rd);
                if (exp_rd) begin
                    a_exp = m_base + 29'(m_req);
                    check("avm_address", avm_address, a_exp);
                    check("avm_burstcount", avm_burstcount, exp_burst(m_req));
                end
            end
            if (!reset_reset && st_valid === 1'b1 && st_ready === 1'b1) begin
                if (st_sop === 1'b1) sop_at = dut_xfers;
                if (st_eop === 1'b1) eop_at = dut_xfers;
                dut_xfers++;
            end
            if (frame_done === 1'b1) done_cnt++;
            if (reset_reset) begin
                m_active = 0; m_done = 0; m_req = 0; m_ret = 0; m_pop = 0;
            end else begin
                if (avm_read === 1'b1 && avm_waitrequest) stall_seen++;
                if (avm_read === 1'b1 && !avm_waitrequest) begin
                    for (int i = 0; i < int'(avm_burstcount); i++) begin
                        a_exp = avm_address + 29'(i);
                        slave_q.push_back(a_exp);
                    end
                    bl_addr.push_back(avm_address);
                    bl_cnt.push_back(int'(avm_burstcount));
                    m_req += exp_burst(m_req);
                    m_acc++;
                end
                if (avm_readdatavalid && m_active) m_ret++;
                eop_now = 0;
                if (avail > 0 && st_ready) begin
                    eop_now = (m_pop == FW - 1);
                    m_pop++;
                end
                start_ok = frame_start && !m_active && !m_done;
                m_done = eop_now;
                if (eop_now) m_active = 0;
                if (start_ok) begin
                    m_active = 1; m_base = frame_base;
                    m_req = 0; m_ret = 0; m_pop = 0; m_acc = 0;
                    bl_addr.delete(); bl_cnt.delete();
                end
            end
        end
    end

    // Avalon slave and stream sink, driven just after the rising edge
    initial begin : driver
        forever begin
            @(posedge clk_clk);
            #1;
            if (slave_q.size() > 0 && (rdv_mode == 0 || $urandom_range(0, 2) != 0)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = word_of(slave_q.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = {$urandom, $urandom};
            end
            case (wr_mode)
                1: avm_waitrequest = ($urandom_range(0, 2) == 0);
                2: begin
                    avm_waitrequest = avm_read && (m_acc == 1) && (stall_cnt < 5);
                    if (avm_waitrequest) stall_cnt++;
                end
                default: avm_waitrequest = 1'b0;
            endcase
            case (rdy_mode)
                1: st_ready = 1'b0;
                2: st_ready = 1'($urandom_range(0, 1));
                default: st_ready = 1'b1;
            endcase
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_avm_read"}, avm_read, 0);
        check({tag, "_avm_address"}, avm_address, 0);
        check({tag, "_avm_burstcount"}, avm_burstcount, 0);
        check({tag, "_st_valid"}, st_valid, 0);
        check({tag, "_st_data"}, st_data, 0);
        check({tag, "_st_sop"}, st_sop, 0);
        check({tag, "_st_eop"}, st_eop, 0);
    endtask

    task automatic start_frame(input logic [28:0] base);
        @(posedge clk_clk);
        #1;
        frame_base = base; frame_start = 1'b1;
        dut_xfers = 0; sop_at = -1; eop_at = -1; stall_cnt = 0; stall_seen = 0;
        @(posedge clk_clk);
        #1;
        frame_start = 1'b0; frame_base = 29'($urandom);
        check("first_req_read", avm_read, 1);
        check("first_req_addr", avm_address, base);
        check("first_req_bc", avm_burstcount, BL);
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int n = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk_clk);
            n++;
        end
        check("frame_done_within_budget", done_cnt != c0, 1);
    endtask

    task automatic check_frame_order(input string tag);
        check({tag, "_sop_index"}, sop_at, 0);
        check({tag, "_eop_index"}, eop_at, FW - 1);
        check({tag, "_words"}, dut_xfers, FW);
    endtask

    initial begin : main
        int d0, n, sum;
        reset_reset = 1'b1; frame_start = 1'b0; frame_base = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0; st_ready = 1'b1;
        wr_mode = 0; rdv_mode = 0; rdy_mode = 0;
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        check_all_zero("reset");
        chk_en = 1;

        // basic frame: bursts 16,16,8
        d0 = done_cnt;
        start_frame(29'h0000_1000);
        wait_done(400);
        check("basic_busy_fell", busy, 0);
        check("basic_bursts", bl_cnt.size(), 3);
        if (bl_cnt.size() == 3) begin
            check("basic_bc0", bl_cnt[0], 16);
            check("basic_bc1", bl_cnt[1], 16);
            check("basic_bc2", bl_cnt[2], 8);
            check("basic_addr1", bl_addr[1], 29'h0000_1010);
            check("basic_addr2", bl_addr[2], 29'h0000_1020);
        end
        check_frame_order("basic");
        repeat (3) @(negedge clk_clk);
        check("basic_one_done", done_cnt - d0, 1);

        // waitrequest held on the second burst
        wr_mode = 2;
        start_frame(29'h0012_3450);
        wait_done(400);
        check("stall_cycles", stall_seen, 5);
        check("stall_accepts", bl_cnt.size(), 3);
        check_frame_order("stall");
        wr_mode = 0;

        // downstream stalled: requests stop at FIFO depth
        rdy_mode = 1;
        start_frame(29'h0000_0200);
        repeat (60) @(negedge clk_clk);
        sum = 0;
        foreach (bl_cnt[i]) sum += bl_cnt[i];
        check("backpressure_requested", sum, FD);
        check("backpressure_read_low", avm_read, 0);
        check("backpressure_head", st_data, word_of(29'h0000_0200));
        rdy_mode = 0;
        wait_done(400);
        check_frame_order("backpressure");

        // address wrap, then frame_start coinciding with frame_done is ignored
        start_frame(29'h1FFF_FFF8);
        n = 0;
        do begin
            @(posedge clk_clk);
            #1;
            n++;
        end while (frame_done !== 1'b1 && n < 400);
        check("wrap_done_seen", frame_done, 1);
        frame_start = 1'b1; frame_base = 29'h0000_0040;
        @(posedge clk_clk);
        #1;
        frame_start = 1'b0;
        check("start_on_done_busy", busy, 0);
        check("start_on_done_read", avm_read, 0);
        check("wrap_bursts", bl_cnt.size(), 3);
        if (bl_cnt.size() == 3) begin
            check("wrap_addr0", bl_addr[0], 29'h1FFF_FFF8);
            check("wrap_addr1", bl_addr[1], 29'h0000_0008);
            check("wrap_addr2", bl_addr[2], 29'h0000_0018);
        end
        check_frame_order("wrap");

        // reset mid-frame, late beats dropped, clean restart
        rdv_mode = 1;
        start_frame(29'h0000_3000);
        n = 0;
        while (dut_xfers < 20 && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        check("midreset_reached_20", dut_xfers >= 20, 1);
        d0 = done_cnt;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        check_all_zero("midreset");
        n = 0;
        while (slave_q.size() > 0 && n < 200) begin
            @(negedge clk_clk);
            n++;
        end
        repeat (3) @(negedge clk_clk);
        check("midreset_late_dropped", st_valid, 0);
        check("midreset_no_done", done_cnt - d0, 0);
        rdv_mode = 0;
        start_frame(29'h0000_5000);
        wait_done(400);
        check_frame_order("restart");

        // randomized handshakes
        wr_mode = 1; rdv_mode = 1; rdy_mode = 2;
        for (int f = 0; f < 6; f++) begin
            start_frame(29'($urandom));
            wait_done(3000);
            check_frame_order("random");
        end
        wr_mode = 0; rdv_mode = 0; rdy_mode = 0;
        repeat (5) @(negedge clk_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
